// File: rtl/bcd_seg7_scan.sv
// Four-digit common-anode seven-segment scanner fed by packed BCD with per-digit decimal points.
// Optional leading-zero blanking is enabled by defining BCD_SEG7_LZ_BLANK_EN.
module bcd_seg7_scan #(
  parameter int CLK_DIV    = 50000,
  parameter int GAP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CMAX  = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t           state_q, state_d;
  logic [1:0]       digit_q, digit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      sbcd_q, sbcd_d;
  logic [3:0]       sdp_q, sdp_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       nib_d;
  logic             blank_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    cnt_d   = cnt_q;
    sbcd_d  = sbcd_q;
    sdp_d   = sdp_q;
    // Shadows reload on any load; scan position is independent of it.
    if (load) begin
      sbcd_d = bcd_in;
      sdp_d  = dp_in;
    end
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SHOW;
          digit_d = 2'd0;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d = '0;
          if (GAP_CYCLES == 0) digit_d = digit_q + 2'd1;
          else                 state_d = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          digit_d = digit_q + 2'd1;
          state_d = SHOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef BCD_SEG7_LZ_BLANK_EN
  logic [3:0] lz_d;
  always_comb begin
    lz_d[3] = (sbcd_d[15:12] == 4'd0);
    lz_d[2] = lz_d[3] && (sbcd_d[11:8] == 4'd0);
    lz_d[1] = lz_d[2] && (sbcd_d[7:4] == 4'd0);
    lz_d[0] = 1'b0;
  end
  assign blank_d = lz_d[digit_d];
`else
  assign blank_d = 1'b0;
`endif

  // Outputs are computed from next-state so they land on the same edge as the state.
  always_comb begin
    nib_d = sbcd_d[{digit_d, 2'b00} +: 4];
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (state_d == SHOW) begin
      dp_d = ~sdp_d[digit_d];
      if (!blank_d) begin
        an_d  = ~(4'b0001 << digit_d);
        seg_d = seg_decode(nib_d);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      digit_q <= 2'd0;
      cnt_q   <= '0;
      sbcd_q  <= 16'h0000;
      sdp_q   <= 4'h0;
      an_q    <= 4'b1111;
      seg_q   <= 7'b1111111;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      cnt_q   <= cnt_d;
      sbcd_q  <= sbcd_d;
      sdp_q   <= sdp_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Randomized and directed bench for bcd_seg7_scan against a time-position display model.
module tb_bcd_seg7_scan;
  localparam int CLK_DIV = 4;
  localparam int GAP     = 1;
  localparam int SLOT    = CLK_DIV + GAP;
  localparam int SCAN    = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bcd_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int total = 0;
  int bad   = 0;

  bcd_seg7_scan #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  // Model: scanning is just a position in time since the first load.
  bit          m_active = 0;
  int          m_pos = 0;
  logic [15:0] m_bcd = 16'h0;
  logic [3:0]  m_dp = 4'h0;
  bit          chk_en = 0;

  function automatic logic [6:0] dec(input int n);
    logic [6:0] t [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (n > 9) return 7'b0111111;
    return t[n];
  endfunction

  function automatic logic [11:0] expect_out();
    int d, w;
    logic [15:0] hi;
    if (!m_active) return 12'hFFF;
    d = m_pos / SLOT;
    w = m_pos % SLOT;
    if (w >= CLK_DIV) return 12'hFFF;
    hi = m_bcd >> (4 * d);
`ifdef BCD_SEG7_LZ_BLANK_EN
    if (d > 0 && hi == 16'h0) return {4'hF, 7'h7F, ~m_dp[d]};
`endif
    return {~(4'b0001 << d), dec(int'(hi[3:0])), ~m_dp[d]};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_active = 0; m_pos = 0; m_bcd = 16'h0; m_dp = 4'h0;
    end else begin
      if (m_active) m_pos = (m_pos + 1) % SCAN;
      else if (load) begin m_active = 1; m_pos = 0; end
      if (load) begin m_bcd = bcd_in; m_dp = dp_in; end
    end
  end

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual{an,seg,dp}=%h required=%h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) if (chk_en) chk("model", {an, seg, dp}, expect_out());

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [3:0] ea, input logic [6:0] es, input logic ed);
    chk(name, {an, seg, dp}, {ea, es, ed});
  endtask

  initial begin
    tick(2);
    chk_en = 1;
    lit("reset", 4'hF, 7'h7F, 1'b1);
    rst = 0;
    tick(50);
    lit("idle50", 4'hF, 7'h7F, 1'b1);

    load = 1; bcd_in = 16'h0123; dp_in = 4'b0010;
    tick();
    load = 0; bcd_in = 16'hFFFF; dp_in = 4'hF;
    lit("d0_first", 4'b1110, 7'b0110000, 1'b1);
    tick(4);
    lit("gap0", 4'hF, 7'h7F, 1'b1);
    tick();
    lit("d1_dp", 4'b1101, 7'b0100100, 1'b0);
    tick(5);
    lit("d2", 4'b1011, 7'b1111001, 1'b1);
    tick(5);
`ifdef BCD_SEG7_LZ_BLANK_EN
    lit("d3_blank", 4'hF, 7'h7F, 1'b1);
`else
    lit("d3_zero", 4'b0111, 7'b1000000, 1'b1);
`endif
    tick(5);
    lit("wrap", 4'b1110, 7'b0110000, 1'b1);
    tick(6);
    load = 1; bcd_in = 16'h0950; dp_in = 4'h0;
    tick();
    load = 0;
    lit("midshow", 4'b1101, 7'b0010010, 1'b1);
    tick(2);
    lit("midshow_gap", 4'hF, 7'h7F, 1'b1);
    tick(9);
    load = 1; bcd_in = 16'h1237; dp_in = 4'h0;
    tick();
    load = 0;
    lit("endslot_gap", 4'hF, 7'h7F, 1'b1);
    tick();
    lit("endslot_new", 4'b1110, 7'b1111000, 1'b1);
    tick(14);
    lit("gap2", 4'hF, 7'h7F, 1'b1);
    rst = 1;
    tick();
    rst = 0;
    lit("rst_mid", 4'hF, 7'h7F, 1'b1);
    tick(7);
    lit("rst_idle", 4'hF, 7'h7F, 1'b1);
    load = 1; bcd_in = 16'h00AF; dp_in = 4'h0;
    tick();
    load = 0;
    lit("dash0", 4'b1110, 7'b0111111, 1'b1);
    tick(5);
    lit("dash1", 4'b1101, 7'b0111111, 1'b1);
    tick(5);
`ifdef BCD_SEG7_LZ_BLANK_EN
    lit("af_d2", 4'hF, 7'h7F, 1'b1);
`else
    lit("af_d2", 4'b1011, 7'b1000000, 1'b1);
`endif

    // Held load: shadows follow inputs every clock while scanning continues.
    load = 1;
    for (int i = 0; i < 30; i++) begin
      bcd_in = 16'($urandom); dp_in = 4'($urandom);
      tick();
    end
    load = 0;

    for (int i = 0; i < 3000; i++) begin
      load   = ($urandom_range(0, 15) == 0);
      rst    = ($urandom_range(0, 299) == 0);
      dp_in  = 4'($urandom);
      case ($urandom_range(0, 3))
        0: bcd_in = 16'($urandom);
        1: bcd_in = 16'($urandom_range(0, 9));
        2: bcd_in = 16'($urandom_range(0, 9)) << 4 | 16'($urandom_range(0, 9));
        default: bcd_in = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                           4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      endcase
      tick();
    end
    rst = 0; load = 0;
    tick(2);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
